matmul_dispatcher: RTL and testbench

Hardware initiator for the 2x2 matrix multiplier: queues packed operand pairs, drives the multiplier's `start`/`done` handshake one operation at a time, and returns each packed 32-bit result on a valid/ready output stream in issue order. It replaces bench-style start/wait sequencing and sits between the cluster's operand source and the `MatrixMultiplier` instance. It also bounds a hung multiplier with a timeout.

---
 rtl/matmul_pkg.sv | 85 ++++++++
 rtl/matmul_op_fifo.sv | 62 ++++++
 rtl/matmul_dispatcher.sv | 115 +++++++++++
 tb/tb_matmul_dispatcher.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared widths, dispatcher state encoding and 2x2 operand/result packing helpers
// for the matrix-multiplier dispatcher.
package matmul_pkg;

    localparam int ELEM_W     = 4;
    localparam int RES_ELEM_W = 8;
    localparam int OPND_W     = 4 * ELEM_W;
    localparam int RES_W      = 4 * RES_ELEM_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } dispatch_state_t;

    // Row-major packing: element 00 occupies the most significant slot.
    typedef struct packed {
        logic [ELEM_W-1:0] e00;
        logic [ELEM_W-1:0] e01;
        logic [ELEM_W-1:0] e10;
        logic [ELEM_W-1:0] e11;
    } opnd_t;

    typedef struct packed {
        logic [RES_ELEM_W-1:0] e00;
        logic [RES_ELEM_W-1:0] e01;
        logic [RES_ELEM_W-1:0] e10;
        logic [RES_ELEM_W-1:0] e11;
    } res_t;

    typedef struct packed {
        opnd_t a;
        opnd_t b;
    } op_pair_t;

    function automatic opnd_t pack_opnd(input logic [ELEM_W-1:0] e00,
                                        input logic [ELEM_W-1:0] e01,
                                        input logic [ELEM_W-1:0] e10,
                                        input logic [ELEM_W-1:0] e11);
        opnd_t m;
        m.e00 = e00;
        m.e01 = e01;
        m.e10 = e10;
        m.e11 = e11;
        return m;
    endfunction

    function automatic logic [ELEM_W-1:0] opnd_elem(input opnd_t m, input logic [1:0] idx);
        logic [ELEM_W-1:0] e;
        e = m.e00;
        case (idx)
            2'd1:    e = m.e01;
            2'd2:    e = m.e10;
            2'd3:    e = m.e11;
            default: e = m.e00;
        endcase
        return e;
    endfunction

    function automatic res_t pack_res(input logic [RES_ELEM_W-1:0] e00,
                                      input logic [RES_ELEM_W-1:0] e01,
                                      input logic [RES_ELEM_W-1:0] e10,
                                      input logic [RES_ELEM_W-1:0] e11);
        res_t r;
        r.e00 = e00;
        r.e01 = e01;
        r.e10 = e10;
        r.e11 = e11;
        return r;
    endfunction

    function automatic logic [RES_ELEM_W-1:0] res_elem(input res_t r, input logic [1:0] idx);
        logic [RES_ELEM_W-1:0] e;
        e = r.e00;
        case (idx)
            2'd1:    e = r.e01;
            2'd2:    e = r.e10;
            2'd3:    e = r.e11;
            default: e = r.e00;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/matmul_op_fifo.sv
// Operand-pair FIFO: DEPTH entries of W bits, head visible combinationally.
// Push ignored when full, pop ignored when empty; count is the registered occupancy.
module matmul_op_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          do_push;
    logic          do_pop;

    assign full     = (occ == FULL_OCC);
    assign empty    = (occ == '0);
    assign count    = occ;
    assign head_dat = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + (AW + 1)'(1);
                2'b01:   occ <= occ - (AW + 1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/matmul_dispatcher.sv
// Queues 2x2 operand pairs and runs the multiplier start/done handshake one op at a time,
// returning results in push order on a valid/ready stream; a hung multiplier is bounded by TIMEOUT.
module matmul_dispatcher
    import matmul_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPND_W-1:0]        in_a,
    input  logic [OPND_W-1:0]        in_b,
    output logic [OPND_W-1:0]        mm_a,
    output logic [OPND_W-1:0]        mm_b,
    output logic                     mm_start,
    input  logic                     mm_done,
    input  logic [RES_W-1:0]         mm_c,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RES_W-1:0]         out_c,
    output logic                     out_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    dispatch_state_t state;
    op_pair_t        push_pair;
    op_pair_t        head_pair;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic            done_prev;
    logic            done_rise;
    logic [TW-1:0]   tmo_cnt;

    assign push_pair = {in_a, in_b};
    assign in_ready  = !fifo_full;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign done_rise = mm_done && !done_prev;
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE) || !fifo_empty;

    matmul_op_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(op_pair_t))
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (in_valid),
        .push_dat (push_pair),
        .pop      (fifo_pop),
        .head_dat (head_pair),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (count)
    );

    // mm_start is registered: it is high in the first WAIT cycle, so the multiplier
    // samples it one edge after ISSUE and the first counted WAIT edge follows.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mm_a      <= '0;
            mm_b      <= '0;
            mm_start  <= 1'b0;
            out_c     <= '0;
            out_err   <= 1'b0;
            tmo_cnt   <= '0;
            done_prev <= 1'b0;
        end else begin
            done_prev <= mm_done;
            mm_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        mm_a  <= head_pair.a;
                        mm_b  <= head_pair.b;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mm_start <= 1'b1;
                    tmo_cnt  <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // Only a fresh 0->1 transition completes; a level left high is ignored.
                    if (done_rise) begin
                        out_c   <= mm_c;
                        out_err <= 1'b0;
                        state   <= HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        out_c   <= '0;
                        out_err <= 1'b1;
                        state   <= HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_dispatcher.sv
// Scoreboard bench for matmul_dispatcher with a behavioural multiplier model.
module tb_matmul_dispatcher;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [15:0] mm_a;
    logic [15:0] mm_b;
    logic        mm_start;
    logic        mm_done;
    logic [31:0] mm_c;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_c;
    logic        out_err;
    logic        busy;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;
    int n_starts = 0;

    logic [32:0] sb[$];

    // Multiplier model controls
    bit          stall = 1'b0;
    int          lat = 5;
    bit          man_mode = 1'b0;
    bit          man_done = 1'b0;
    logic [31:0] man_c = '0;

    // Directed vectors: A, B, hand-computed C
    logic [15:0] va [6] = '{16'h1234, 16'h1000, 16'h1001, 16'h2113, 16'h0100, 16'h7777};
    logic [15:0] vb [6] = '{16'h5678, 16'h1000, 16'hABCD, 16'h1021, 16'h00F0, 16'h7777};
    logic [31:0] vc [6] = '{32'h13162B32, 32'h01000000, 32'h0A0B0C0D, 32'h04010703,
                            32'h0F000000, 32'h62626262};

    matmul_dispatcher #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_start  (mm_start),
        .mm_done   (mm_done),
        .mm_c      (mm_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_err   (out_err),
        .busy      (busy),
        .count     (count)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic [7:0] c00, c01, c10, c11;
        c00 = 8'(a[15:12]) * 8'(b[15:12]) + 8'(a[11:8]) * 8'(b[7:4]);
        c01 = 8'(a[15:12]) * 8'(b[11:8])  + 8'(a[11:8]) * 8'(b[3:0]);
        c10 = 8'(a[7:4])   * 8'(b[15:12]) + 8'(a[3:0])  * 8'(b[7:4]);
        c11 = 8'(a[7:4])   * 8'(b[11:8])  + 8'(a[3:0])  * 8'(b[3:0]);
        return {c00, c01, c10, c11};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [15:0] a, input logic [15:0] b, input logic [32:0] exp,
                           input bit track, output bit acc);
        acc = in_ready;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        if (acc && track) sb.push_back(exp);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_sig(input string name, input bit use_start, input int budget);
        int i;
        i = 0;
        while (!(use_start ? mm_start : out_valid) && i < budget) begin
            tick();
            i++;
        end
        if (!(use_start ? mm_start : out_valid)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no event within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i;
        i = 0;
        while (sb.size() != 0 && i < budget) begin
            tick();
            i++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: %0d results outstanding after %0d cycles", name, sb.size(), budget);
        end
        tick();
        tick();
    endtask

    // Behavioural multiplier: done rises lat cycles after start, holds until next start.
    initial begin
        logic [15:0] pa, pb;
        int          cnt;
        bit          pend;
        pa = '0; pb = '0; cnt = 0; pend = 1'b0;
        mm_done = 1'b0;
        mm_c = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend = 1'b0;
                mm_done = 1'b0;
            end else if (man_mode) begin
                mm_done = man_done;
                mm_c = man_c;
            end else if (mm_start) begin
                pa = mm_a;
                pb = mm_b;
                cnt = lat;
                pend = 1'b1;
                mm_done = 1'b0;
            end else if (pend && !stall) begin
                if (cnt > 1) begin
                    cnt--;
                end else begin
                    mm_c = ref_mul(pa, pb);
                    mm_done = 1'b1;
                    pend = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset && mm_start) n_starts++;
    end

    // Monitor: every accepted output is compared against the head of the scoreboard.
    initial forever begin
        logic [32:0] exp;
        @(negedge clk);
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got err=%0b c=%h required no output", out_err, out_c);
            end else begin
                exp = sb.pop_front();
                check("result", {31'b0, out_err, out_c}, {31'b0, exp});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int s0;
        bit exp_acc [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset values
        tick();
        tick();
        check("rst_mm_a", 64'(mm_a), 64'h0);
        check("rst_mm_b", 64'(mm_b), 64'h0);
        check("rst_mm_start", 64'(mm_start), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_c", 64'(out_c), 64'h0);
        check("rst_out_err", 64'(out_err), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_count", 64'(count), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        reset = 1'b1;
        tick();

        // Single op: start pulse in the cycle after edge k+2
        s0 = n_starts;
        push_op(va[0], vb[0], {1'b0, vc[0]}, 1'b1, acc);
        check("single_count", 64'(count), 64'h1);
        check("single_busy", 64'(busy), 64'h1);
        tick();
        check("single_start_k1", 64'(mm_start), 64'h0);
        tick();
        check("single_start_k2", 64'(mm_start), 64'h1);
        check("single_mm_a", 64'(mm_a), 64'h1234);
        check("single_mm_b", 64'(mm_b), 64'h5678);
        tick();
        check("single_start_k3", 64'(mm_start), 64'h0);
        wait_drain("single_drain", 200);
        check("single_starts", 64'(n_starts - s0), 64'h1);

        // Back-pressure: 1 in flight + 4 queued, sixth refused
        stall = 1'b1;
        s0 = n_starts;
        for (int i = 0; i < 6; i++) begin
            push_op(va[i], vb[i], {1'b0, vc[i]}, 1'b1, acc);
            check($sformatf("bp_accept%0d", i), 64'(acc), 64'(exp_acc[i]));
        end
        check("bp_count", 64'(count), 64'h4);
        check("bp_in_ready", 64'(in_ready), 64'h0);
        tick();
        stall = 1'b0;
        wait_drain("bp_drain", 500);
        check("bp_starts", 64'(n_starts - s0), 64'h5);

        // Output stall: result and start activity frozen while out_ready is low
        out_ready = 1'b0;
        push_op(va[5], vb[5], {1'b0, vc[5]}, 1'b1, acc);
        push_op(va[1], vb[1], {1'b0, vc[1]}, 1'b1, acc);
        wait_sig("ostall_valid", 1'b0, 100);
        s0 = n_starts;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("ostall_valid", 64'(out_valid), 64'h1);
            check("ostall_c", 64'(out_c), 64'h62626262);
            check("ostall_starts", 64'(n_starts - s0), 64'h0);
        end
        out_ready = 1'b1;
        tick();
        check("restart_h0", 64'(mm_start), 64'h0);
        tick();
        check("restart_h1", 64'(mm_start), 64'h0);
        tick();
        check("restart_h2", 64'(mm_start), 64'h1);
        wait_drain("ostall_drain", 200);

        // Hung multiplier: abort on the 64th WAIT edge, then the next op runs normally
        stall = 1'b1;
        out_ready = 1'b0;
        push_op(va[2], vb[2], {1'b1, 32'h0}, 1'b1, acc);
        push_op(va[3], vb[3], {1'b0, vc[3]}, 1'b1, acc);
        wait_sig("hung_start", 1'b1, 50);
        for (int j = 1; j <= 63; j++) tick();
        check("hung_valid_63", 64'(out_valid), 64'h0);
        tick();
        check("hung_valid_64", 64'(out_valid), 64'h1);
        check("hung_err", 64'(out_err), 64'h1);
        check("hung_c", 64'(out_c), 64'h0);
        stall = 1'b0;
        tick();
        out_ready = 1'b1;
        wait_drain("hung_drain", 300);

        // Stuck done: a level left high must not complete; the next rise does
        man_c = 32'hDEADBEEF;
        man_done = 1'b1;
        man_mode = 1'b1;
        tick();
        push_op(va[3], vb[3], {1'b0, vc[3]}, 1'b1, acc);
        wait_sig("stuck_start", 1'b1, 50);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stuck_no_valid", 64'(out_valid), 64'h0);
        end
        man_done = 1'b0;
        tick();
        tick();
        check("stuck_low_no_valid", 64'(out_valid), 64'h0);
        man_c = 32'h04010703;
        man_done = 1'b1;
        wait_sig("stuck_valid", 1'b0, 20);
        wait_drain("stuck_drain", 100);
        man_mode = 1'b0;
        tick();

        // Reset mid-WAIT with three queued: everything discarded
        stall = 1'b1;
        for (int i = 0; i < 4; i++) push_op(va[i], vb[i], 33'h0, 1'b0, acc);
        check("prerst_count", 64'(count), 64'h3);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("arst_mm_a", 64'(mm_a), 64'h0);
        check("arst_mm_start", 64'(mm_start), 64'h0);
        check("arst_out_valid", 64'(out_valid), 64'h0);
        check("arst_out_c", 64'(out_c), 64'h0);
        check("arst_busy", 64'(busy), 64'h0);
        check("arst_count", 64'(count), 64'h0);
        check("arst_in_ready", 64'(in_ready), 64'h1);
        tick();
        reset = 1'b1;
        stall = 1'b0;
        s0 = n_starts;
        for (int i = 0; i < 100; i++) tick();
        check("postrst_starts", 64'(n_starts - s0), 64'h0);
        check("postrst_busy", 64'(busy), 64'h0);
        check("scoreboard_empty", 64'(sb.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
